// File: rtl/multiply_unit.sv
// multiply_unit: 32x32 iterative shift-add multiplier with MULT/MADD/MSUB variants writing HI/LO
module multiply_unit (
    input  logic        clock,
    input  logic        reset,
    input  logic        OP_mult,
    input  logic        OP_multu,
    input  logic        OP_madd,
    input  logic        OP_maddu,
    input  logic        OP_msub,
    input  logic        OP_msubu,
    input  logic [31:0] Multiplicand,
    input  logic [31:0] Multiplier,
    input  logic [31:0] HI_in,
    input  logic [31:0] LO_in,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic        Stall
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIXUP} state_t;
    state_t      r_state, w_next;
    logic [4:0]  r_count;
    logic [64:0] r_p;
    logic [31:0] r_a;
    logic        r_neg;
    logic [63:0] r_acc;
    logic [1:0]  r_kind;
    logic [31:0] r_hi, r_lo;
    logic        w_start, w_signed;
    logic [2:0]  w_op;
    logic [31:0] w_abs_a, w_abs_b;
    logic [32:0] w_sum;
    logic [63:0] w_prod, w_result;
    // op code: bit0 = unsigned, bits[2:1] = 0 plain, 1 accumulate-add, 2 accumulate-subtract
    assign w_start  = OP_mult | OP_multu | OP_madd | OP_maddu | OP_msub | OP_msubu;
    assign w_op     = OP_mult ? 3'd0 : OP_multu ? 3'd1 : OP_madd ? 3'd2 :
                      OP_maddu ? 3'd3 : OP_msub ? 3'd4 : 3'd5;
    assign w_signed = ~w_op[0];
    assign w_abs_a  = (w_signed && Multiplicand[31]) ? -Multiplicand : Multiplicand;
    assign w_abs_b  = (w_signed && Multiplier[31]) ? -Multiplier : Multiplier;
    assign w_sum    = r_p[0] ? {1'b0, r_p[63:32]} + {1'b0, r_a} : r_p[64:32];
    assign HI       = r_hi;
    assign LO       = r_lo;
    // state register
    always_ff @(posedge clock) begin
        r_state <= reset ? S_IDLE : w_next;
    end
    // next state: a start always (re)enters RUN; RUN ends after count 0, FIXUP lasts one cycle
    always_comb begin
        w_next = w_start ? S_RUN :
                 (r_state == S_RUN) ? ((r_count == 5'd0) ? S_FIXUP : S_RUN) : S_IDLE;
    end
    // outputs: stall while busy; signed fixup and accumulate of the finished product
    always_comb begin
        Stall    = r_state != S_IDLE;
        w_prod   = r_neg ? -r_p[63:0] : r_p[63:0];
        w_result = r_kind[1] ? r_acc - w_prod : r_kind[0] ? r_acc + w_prod : w_prod;
    end
    // datapath: capture at start, one shift-add step per RUN cycle, commit HI/LO in FIXUP
    always_ff @(posedge clock) begin
        if (reset) begin
            r_count <= '0;
            r_p     <= '0;
            r_a     <= '0;
            r_neg   <= 1'b0;
            r_acc   <= '0;
            r_kind  <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else if (w_start) begin
            r_count <= 5'd31;
            r_p     <= {33'b0, w_abs_b};
            r_a     <= w_abs_a;
            r_neg   <= w_signed & (Multiplicand[31] ^ Multiplier[31]);
            r_kind  <= w_op[2:1];
            r_acc   <= (w_op[2:1] != 2'd0) ? {HI_in, LO_in} : '0;
        end else if (r_state == S_RUN) begin
            r_p     <= {1'b0, w_sum, r_p[31:1]};
            r_count <= r_count - 5'd1;
        end else if (r_state == S_FIXUP) begin
            r_hi    <= w_result[63:32];
            r_lo    <= w_result[31:0];
        end
    end
endmodule

// File: tb/tb_multiply_unit.sv
// tb_multiply_unit: directed and random checks of multiply_unit against an arithmetic reference
module tb_multiply_unit;
    logic        clock = 1'b0;
    logic        reset;
    logic [5:0]  ops;
    logic [31:0] Multiplicand, Multiplier, HI_in, LO_in;
    logic [31:0] HI, LO;
    logic        Stall;
    int          total = 0;
    int          bad = 0;
    logic [63:0] cur = '0;

    multiply_unit dut (
        .clock(clock), .reset(reset),
        .OP_mult(ops[0]), .OP_multu(ops[1]), .OP_madd(ops[2]),
        .OP_maddu(ops[3]), .OP_msub(ops[4]), .OP_msubu(ops[5]),
        .Multiplicand(Multiplicand), .Multiplier(Multiplier),
        .HI_in(HI_in), .LO_in(LO_in), .HI(HI), .LO(LO), .Stall(Stall)
    );

    always #5 clock = ~clock;

    // code 0..5 = mult, multu, madd, maddu, msub, msubu
    function automatic logic [63:0] model(input int code, input logic [31:0] a, input logic [31:0] b,
                                          input logic [63:0] acc);
        logic signed [63:0] sa, sb;
        logic [63:0] p;
        sa = $signed(a);
        sb = $signed(b);
        p = (code % 2 == 1) ? {32'b0, a} * {32'b0, b} : sa * sb;
        return (code / 2 == 0) ? p : (code / 2 == 1) ? acc + p : acc - p;
    endfunction

    function automatic int prio(input logic [5:0] m);
        for (int i = 0; i < 6; i++) if (m[i]) return i;
        return 0;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic start(input logic [5:0] m, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] hi, input logic [31:0] lo);
        ops = m;
        Multiplicand = a;
        Multiplier = b;
        HI_in = hi;
        LO_in = lo;
        @(negedge clock);
        ops = '0;
        Multiplicand = $urandom;
        Multiplier = $urandom;
        HI_in = $urandom;
        LO_in = $urandom;
    endtask

    task automatic watch(input int n);
        for (int i = 0; i < n; i++) begin
            check("stall_high", {63'b0, Stall}, 64'd1);
            check("hold", {HI, LO}, cur);
            @(negedge clock);
        end
    endtask

    task automatic finish_op(input string tag, input logic [63:0] exp);
        check("stall_low", {63'b0, Stall}, 64'd0);
        check(tag, {HI, LO}, exp);
        cur = exp;
    endtask

    task automatic full(input string tag, input logic [5:0] m, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] hi, input logic [31:0] lo);
        logic [63:0] exp;
        exp = model(prio(m), a, b, {hi, lo});
        start(m, a, b, hi, lo);
        watch(33);
        finish_op(tag, exp);
    endtask

    initial begin
        logic [5:0]  m;
        logic [31:0] a, b;
        reset = 1'b1;
        ops = '0;
        Multiplicand = '0;
        Multiplier = '0;
        HI_in = '0;
        LO_in = '0;
        repeat (2) @(negedge clock);
        check("reset_stall", {63'b0, Stall}, 64'd0);
        check("reset_hilo", {HI, LO}, 64'd0);
        reset = 1'b0;
        @(negedge clock);
        full("multu_max", 6'b000010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h0);
        check("multu_max_const", {HI, LO}, 64'hFFFFFFFE_00000001);
        full("mult_minint", 6'b000001, 32'h80000000, 32'h80000000, 32'h0, 32'h0);
        check("mult_minint_const", {HI, LO}, 64'h40000000_00000000);
        full("mult_neg1x7", 6'b000001, 32'hFFFFFFFF, 32'h7, 32'h0, 32'h0);
        check("mult_neg1x7_const", {HI, LO}, 64'hFFFFFFFF_FFFFFFF9);
        full("madd_carry", 6'b000100, 32'h1, 32'h1, 32'h0, 32'hFFFFFFFF);
        check("madd_carry_const", {HI, LO}, 64'h00000001_00000000);
        full("msubu_wrap", 6'b100000, 32'h1, 32'h1, 32'h0, 32'h0);
        check("msubu_wrap_const", {HI, LO}, 64'hFFFFFFFF_FFFFFFFF);
        start(6'b000010, 32'd3, 32'd5, 32'h0, 32'h0);
        watch(9);
        start(6'b000001, 32'd2, 32'hFFFFFFFD, 32'h0, 32'h0);
        watch(33);
        finish_op("abort_restart", 64'hFFFFFFFF_FFFFFFFA);
        full("prio_mult_multu", 6'b000011, 32'hFFFFFFFE, 32'd2, 32'h0, 32'h0);
        check("prio_const", {HI, LO}, 64'hFFFFFFFF_FFFFFFFC);
        full("prio_madd_msub", 6'b010100, 32'h12345678, 32'h9ABCDEF0, 32'h11111111, 32'h22222222);
        for (int i = 0; i < 24; i++) begin
            m = 6'($urandom_range(1, 63));
            if (i < 12) m = 6'b1 << (i % 6);
            a = (i % 5 == 0) ? 32'h80000000 : $urandom;
            b = (i % 7 == 0) ? 32'hFFFFFFFF : $urandom;
            full("random", m, a, b, $urandom, $urandom);
        end
        start(6'b000001, 32'hDEADBEEF, 32'h12345678, 32'h0, 32'h0);
        watch(19);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        cur = '0;
        check("midrun_reset_stall", {63'b0, Stall}, 64'd0);
        check("midrun_reset_hilo", {HI, LO}, 64'd0);
        full("post_reset", 6'b001000, 32'hFFFFFFFF, 32'h2, 32'h1, 32'h2);
        reset = 1'b1;
        ops = 6'b000001;
        Multiplicand = 32'd3;
        Multiplier = 32'd5;
        @(negedge clock);
        reset = 1'b0;
        ops = '0;
        cur = '0;
        check("reset_wins_stall", {63'b0, Stall}, 64'd0);
        @(negedge clock);
        check("reset_wins_stall2", {63'b0, Stall}, 64'd0);
        check("reset_wins_hilo", {HI, LO}, 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
